// File: rtl/pipo_load_arbiter_if.sv
// pipo_load_arbiter_if
//   Bundles the requester-side and reader-side signals of the shared
//   PIPO load arbiter.
//
//   req   : per-requester load request (bit i = requester i)
//   data  : packed request words, requester i at [i*WIDTH +: WIDTH]
//   a     : registered shared-register contents
//   owner : index of the requester whose word is held in a
//   valid : a holds a granted word (sticky until reset)
//   ack   : one-hot, single-cycle grant acknowledge
//   busy  : register is inside its post-load hold window
//
//   master : requesters / downstream readers (drive req, data)
//   slave  : the arbiter (drives a, owner, valid, ack, busy)

interface pipo_load_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [WIDTH-1:0]      a;
    logic [IDW-1:0]        owner;
    logic                  valid;
    logic [NREQ-1:0]       ack;
    logic                  busy;

    modport master (
        output req, data,
        input  a, owner, valid, ack, busy
    );

    modport slave (
        input  req, data,
        output a, owner, valid, ack, busy
    );
endinterface

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter
//   Round-robin arbiter and load sequencer in front of one shared
//   WIDTH-bit parallel-in parallel-out holding register. In IDLE the first
//   requesting index at or after the round-robin pointer wins; its word is
//   loaded, it is acknowledged for one cycle, and the register is then held
//   for HOLD cycles (busy high, requests ignored) before the next grant.
//
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : pipo_load_arbiter_if slave modport
//         in : req[NREQ], data[NREQ*WIDTH]
//         out: a[WIDTH], owner[IDW], valid, ack[NREQ], busy
//
//   Parameters: WIDTH (data width), NREQ (2..8 requesters),
//   HOLD (1..15 hold cycles after each load).

module pipo_load_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipo_load_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q;
    logic [IDW-1:0]   owner_q;
    logic             valid_q;
    logic [NREQ-1:0]  ack_q;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW:0]     sum;
    logic [IDW-1:0]   cand;
    logic             grant;

    logic [WIDTH-1:0] words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = bus.data[g*WIDTH +: WIDTH];
    end

    // Rotating priority search: candidates ptr, ptr+1, ... modulo NREQ.
    // sum is one bit wider than the index so ptr+k never overflows before
    // the wrap subtraction.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        if (win == IDW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared register and grant bookkeeping; ack is cleared on every edge
    // that is not a grant so it is high for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            ptr_q   <= '0;
        end else begin
            ack_q <= '0;
            if (grant) begin
                a_q     <= words[win];
                owner_q <= win;
                valid_q <= 1'b1;
                ack_q   <= NREQ'(1) << win;
                ptr_q   <= ptr_d;
            end
        end
    end

    assign bus.a     = a_q;
    assign bus.owner = owner_q;
    assign bus.valid = valid_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
module tb_pipo_load_arbiter;

    logic clk;
    logic rst;
    int unsigned cyc;
    int checks;
    int failures;

    typedef struct {
        int unsigned owner;
        logic [2:0]  word;
        int unsigned edge_no;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    pipo_load_arbiter_if #(.WIDTH(3), .NREQ(4)) bus ();

    pipo_load_arbiter #(
        .WIDTH(3),
        .NREQ (4),
        .HOLD (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard consumer: every observed ack must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ack !== 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: ack=%b at edge %0d, required no grant", bus.ack, cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (bus.ack !== (4'b0001 << mon_e.owner)) begin
                    failures++;
                    $display("FAIL grant_ack: got %b, expected onehot(%0d)", bus.ack, mon_e.owner);
                end
                checks++;
                if (cyc !== mon_e.edge_no) begin
                    failures++;
                    $display("FAIL grant_edge: got edge %0d, expected edge %0d", cyc, mon_e.edge_no);
                end
                checks++;
                if (bus.owner !== 2'(mon_e.owner)) begin
                    failures++;
                    $display("FAIL grant_owner: got %0d, expected %0d", bus.owner, mon_e.owner);
                end
                checks++;
                if (bus.a !== mon_e.word) begin
                    failures++;
                    $display("FAIL grant_word: got %b, expected %b", bus.a, mon_e.word);
                end
                checks++;
                if (bus.valid !== 1'b1) begin
                    failures++;
                    $display("FAIL grant_valid: got %b, expected 1", bus.valid);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: %0d grants outstanding, expected 0", tag, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        bus.req  = 4'($urandom);
        bus.data = 12'($urandom);
        rst = 1'b0;
        #2;
        checks++; if (bus.a !== 3'b000)    begin failures++; $display("FAIL reset_a: got %b, expected 000", bus.a); end
        checks++; if (bus.owner !== 2'd0)  begin failures++; $display("FAIL reset_owner: got %0d, expected 0", bus.owner); end
        checks++; if (bus.valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b, expected 0", bus.valid); end
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b, expected 0000", bus.ack); end
        checks++; if (bus.busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        tick(2);
        bus.req = 4'($urandom);
        tick(1);
        checks++; if (bus.valid !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: valid=%b ack=%b busy=%b, expected 0/0000/0", bus.valid, bus.ack, bus.busy);
        end
        bus.req = 4'b0000;
        rst = 1'b1;
        tick(2);
        checks++; if (bus.a !== 3'b000 || bus.owner !== 2'd0 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL release_regs: a=%b owner=%0d valid=%b, expected 000/0/0", bus.a, bus.owner, bus.valid);
        end
        checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release_ctl: ack=%b busy=%b, expected 0000/0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_single_load();
        int unsigned c;
        c = cyc;
        bus.data = 12'($urandom);
        bus.data[5:3] = 3'b101;
        bus.req = 4'b0010;
        sbq.push_back('{owner: 1, word: 3'b101, edge_no: c + 1});
        sbq.push_back('{owner: 1, word: 3'b110, edge_no: c + 4});
        tick(1);
        checks++; if (bus.a !== 3'b101)    begin failures++; $display("FAIL single_a: got %b, expected 101", bus.a); end
        checks++; if (bus.busy !== 1'b1)   begin failures++; $display("FAIL single_busy1: got %b, expected 1", bus.busy); end
        checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL single_ack: got %b, expected 0010", bus.ack); end
        bus.data[5:3] = 3'b110;
        tick(1);
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL single_ack_drop: got %b, expected 0000", bus.ack); end
        checks++; if (bus.busy !== 1'b1)   begin failures++; $display("FAIL single_busy2: got %b, expected 1", bus.busy); end
        checks++; if (bus.a !== 3'b101)    begin failures++; $display("FAIL single_hold_a: got %b, expected 101", bus.a); end
        tick(1);
        checks++; if (bus.busy !== 1'b0)   begin failures++; $display("FAIL single_busy_end: got %b, expected 0", bus.busy); end
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL single_no_early: got %b, expected 0000", bus.ack); end
        checks++; if (bus.a !== 3'b101 || bus.valid !== 1'b1) begin
            failures++;
            $display("FAIL single_idle_regs: a=%b valid=%b, expected 101/1", bus.a, bus.valid);
        end
        tick(1);
        bus.req = 4'b0000;
        tick(3);
        check_drained("single");
    endtask

    task automatic test_fairness();
        int unsigned c;
        do_reset();
        c = cyc;
        bus.data = 12'b100_011_010_001;
        bus.req  = 4'b1111;
        sbq.push_back('{owner: 0, word: 3'b001, edge_no: c + 1});
        sbq.push_back('{owner: 1, word: 3'b010, edge_no: c + 4});
        sbq.push_back('{owner: 2, word: 3'b011, edge_no: c + 7});
        sbq.push_back('{owner: 3, word: 3'b100, edge_no: c + 10});
        sbq.push_back('{owner: 0, word: 3'b001, edge_no: c + 13});
        tick(13);
        bus.req = 4'b0000;
        tick(3);
        check_drained("fairness");
    endtask

    task automatic test_ignored_during_hold();
        int unsigned c;
        c = cyc;
        bus.data = 12'($urandom);
        bus.data[2:0] = 3'b111;
        bus.req = 4'b0001;
        sbq.push_back('{owner: 0, word: 3'b111, edge_no: c + 1});
        sbq.push_back('{owner: 2, word: 3'b010, edge_no: c + 4});
        tick(1);
        bus.req = 4'b0100;
        bus.data[8:6] = 3'b010;
        tick(1);
        checks++; if (bus.ack !== 4'b0000 || bus.a !== 3'b111 || bus.owner !== 2'd0) begin
            failures++;
            $display("FAIL hold_ignore1: ack=%b a=%b owner=%0d, expected 0000/111/0", bus.ack, bus.a, bus.owner);
        end
        tick(1);
        checks++; if (bus.ack !== 4'b0000 || bus.a !== 3'b111 || bus.owner !== 2'd0) begin
            failures++;
            $display("FAIL hold_ignore2: ack=%b a=%b owner=%0d, expected 0000/111/0", bus.ack, bus.a, bus.owner);
        end
        tick(1);
        bus.req = 4'b0000;
        tick(3);
        check_drained("ignored");
    endtask

    task automatic test_pointer_wrap();
        int unsigned c;
        c = cyc;
        bus.data = 12'($urandom);
        bus.data[11:9] = 3'b011;
        bus.req = 4'b1000;
        sbq.push_back('{owner: 3, word: 3'b011, edge_no: c + 1});
        sbq.push_back('{owner: 0, word: 3'b101, edge_no: c + 4});
        sbq.push_back('{owner: 3, word: 3'b110, edge_no: c + 7});
        tick(1);
        bus.req = 4'b1001;
        bus.data[2:0]  = 3'b101;
        bus.data[11:9] = 3'b110;
        tick(3);
        bus.req = 4'b1000;
        tick(3);
        bus.req = 4'b0000;
        tick(3);
        check_drained("wrap");
    endtask

    task automatic test_reset_mid_hold();
        int unsigned c;
        c = cyc;
        bus.data = 12'($urandom);
        bus.data[8:6]  = 3'b001;
        bus.data[11:9] = 3'b111;
        bus.req = 4'b1100;
        sbq.push_back('{owner: 2, word: 3'b001, edge_no: c + 1});
        tick(1);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.a !== 3'b000)    begin failures++; $display("FAIL midrst_a: got %b, expected 000", bus.a); end
        checks++; if (bus.valid !== 1'b0)  begin failures++; $display("FAIL midrst_valid: got %b, expected 0", bus.valid); end
        checks++; if (bus.busy !== 1'b0)   begin failures++; $display("FAIL midrst_busy: got %b, expected 0", bus.busy); end
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL midrst_ack: got %b, expected 0000", bus.ack); end
        checks++; if (bus.owner !== 2'd0)  begin failures++; $display("FAIL midrst_owner: got %0d, expected 0", bus.owner); end
        tick(1);
        c = cyc;
        sbq.push_back('{owner: 2, word: 3'b001, edge_no: c + 1});
        rst = 1'b1;
        tick(1);
        bus.req = 4'b0000;
        tick(3);
        check_drained("midrst");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.req  = 4'b0000;
        bus.data = '0;
        rst = 1'b1;
        #0;
        test_reset();
        test_single_load();
        test_fairness();
        test_ignored_during_hold();
        test_pointer_wrap();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in parallel-out holding register among NREQ requesters. Each requester presents a request and a parallel data word. The block grants one requester at a time, loads that word into the shared register and acknowledges the winner. It then enforces a hold window before the next load. It sits in front of the shared PIPO storage, and downstream logic reads the registered word, its owner and a valid flag.

## Interface
- WIDTH, 3: register/data width in bits.
- NREQ, 4: number of requesters, range 2..8.
- HOLD, 2: minimum cycles the register is held after a load before the next grant, range 1..15.
- IDW = max(1, clog2(NREQ)): derived width, not overridable.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
- req  in  NREQ  request per requester; bit i = requester i.
- data  in  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- a  out  WIDTH  registered shared-register contents.
- owner  out  IDW  index of requester whose word is in a.
- valid  out  1  a holds a granted word; set on first load.
- ack  out  NREQ  one-hot, one-cycle registered grant acknowledge.
- busy  out  1  high while in HOLD state.

## Operation
- Reset values: a=0, owner=0, valid=0, ack=0, busy=0, round-robin pointer ptr=0, state IDLE, hold counter=0.
- States: IDLE, HOLD.
- **IDLE**
  - If req==0: stay in IDLE, ack=0.
  - Otherwise, winner w = first set req bit searching ptr, ptr+1, … NREQ-1, 0, … (wrap).
  - On the edge: a←data slice w, owner←w, valid←1, ack←one-hot(w), ptr←(w+1) mod NREQ, cnt←HOLD-1, state←HOLD.
- **HOLD**
  - busy=1.
  - ack returns to 0 one cycle after grant.
  - req is ignored.
  - cnt decrements each edge; on the edge where cnt==0, state←IDLE.
- Outside a grant edge, a, owner and valid hold their values. valid never clears except by reset.
- Requester rules:
  - Hold req and data stable until ack is seen.
  - Deassert req on the edge after ack, or keep it high to queue another load.
  - A requester keeping req high is re-granted only when its turn comes again in round-robin order.
- data of non-winning requesters is don't-care.
- Reset asserted mid-HOLD or mid-ack:
  - All outputs go to reset values asynchronously.
  - The in-flight grant is lost; the requester is not acked and re-requests.
- A single requester with req held continuously is re-granted every HOLD+1 cycles.

## Timing
- Grant latency: req high before edge k (state IDLE) → a, owner, valid updated and ack[w]=1 after edge k.
- ack[w] is high for exactly the cycle between edges k and k+1.
- busy is high from edge k until edge k+HOLD.
- State is IDLE after edge k+HOLD; the earliest next grant is at edge k+HOLD+1.
- Minimum load spacing is therefore HOLD+1 cycles (3 at default).
- ack, busy, a, owner and valid are all registered; there are no combinational input-to-output paths.
- Reset deassertion is assumed synchronized externally. The first grant can occur on the first edge with rst high.

## Test plan
- **Reset:** rst=0 with random req/data → a=3'b000, owner=0, valid=0, ack=4'b0000, busy=0. Release rst with req=0 → outputs unchanged.
- **Single load:** req=4'b0010, data slice1=3'b101 at edge k → a=3'b101, owner=1, valid=1, ack=4'b0010 for one cycle, busy high for 2 cycles. Next grant is no earlier than edge k+3.
- **Fairness:** req=4'b1111 held, distinct data 3'b001/010/011/100 → grants in order 0,1,2,3,0 at edges k, k+3, k+6, k+9, k+12. a follows the granted word each time.
- **Ignored during HOLD:** grant req0, then raise req2 during HOLD → no ack or change of a until state returns to IDLE. req2 is granted at edge k+3.
- **Pointer wrap:** after a grant to requester 3, assert req=4'b1001 → requester 0 wins next (ptr wrapped to 0), then requester 3.
- **Reset mid-HOLD:** rst low one cycle after a grant → a=0, valid=0, busy=0, ack=0 immediately. After release, the pending req is granted starting from ptr=0.
